direction_ctrl: RTL and testbench
=================================

DIRECTION_CTRL -- requirements
Module: direction_ctrl

Interface
REQ-001 SHALL have parameter QUEUE_DEPTH, default 2, turn-queue entries, legal 1..4.
REQ-002 SHALL have parameter INIT_DIR, default 2'b01, heading after reset (00 up, 01 right, 10 down, 11 left).
REQ-003 SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports btn_up, btn_right, btn_down, btn_left  input  1 each  debounced button levels, active-high, synchronous to clock.
REQ-006 SHALL have port step  input  1  one-cycle game-tick pulse; the heading advances on it.
REQ-007 SHALL have port direction  output  2  current heading, registered.
REQ-008 SHALL have port turn_pending  output  1  high while at least one queued turn exists, registered.
REQ-009 SHALL have port dropped  output  1  one-cycle pulse, registered, when a press is rejected.

Function
REQ-010 SHALL detect a press per button as level high in the current cycle and low in the previous cycle (registered previous level).
REQ-011 SHALL accept at most one press per cycle, priority up > right > down > left; lower-priority simultaneous presses SHALL pulse dropped.
REQ-012 SHALL validate each press against the reference heading: the tail queue entry if the queue is non-empty, else direction.
REQ-013 SHALL silently discard a press equal to the reference heading (no dropped pulse).
REQ-014 SHALL discard a press equal to the reverse of the reference heading (reference XOR 2'b10) and pulse dropped.
REQ-015 SHALL enqueue a valid press at the tail; with the queue full and step low it SHALL discard it and pulse dropped.
REQ-016 SHALL, when step is high and the queue is non-empty, load direction with the head entry and pop it at that edge; with an empty queue, direction holds.
REQ-017 SHALL, when step and an accepted press coincide, pop and push in the same edge; a full queue then accepts the press.
REQ-018 SHALL validate a press coinciding with step against the pre-pop reference, so the result equals sequential pop-then-push.
REQ-019 SHALL show an enqueued press in turn_pending at the edge after the press cycle; direction changes at the edge sampling step high.
REQ-020 SHALL keep turn_pending = (queue count != 0) after every edge.
REQ-021 SHALL keep the queue count in range 0..QUEUE_DEPTH, with no wrap or overflow of pointers.

Reset
REQ-022 SHALL, while reset_n is low at a rising edge, set direction = INIT_DIR, empty the queue, turn_pending = 0, dropped = 0.
REQ-023 SHALL set the previous-level registers to 1 during reset, so a button held through reset is not a press.
REQ-024 SHALL, on reset asserted mid-operation, discard queued turns and any same-cycle press or step.

Configuration
REQ-025 SHALL, with DIRCTRL_QUEUE_EN defined, implement the QUEUE_DEPTH-entry FIFO per REQ-012..REQ-021.
REQ-026 SHALL, without DIRCTRL_QUEUE_EN, use one pending slot validated against direction only. A newer valid press overwrites the slot (last wins). No full-drop occurs, and QUEUE_DEPTH is ignored.

Verification
REQ-027 SHALL cover: reset with INIT_DIR=01 and btn_up held through and after reset -> direction=01, turn_pending=0, no press detected.
REQ-028 SHALL cover: direction=01, press up, then step two cycles later -> turn_pending=1 one edge after the press; direction=00 after step; turn_pending=0.
REQ-029 SHALL cover: direction=01, press left -> dropped pulses 1 cycle, queue stays empty; press right -> no dropped, queue empty.
REQ-030 SHALL cover: QUEUE_DEPTH=2, direction=01, press up then left then down with no step -> queue {00,11}, third press dropped; two steps -> direction 00 then 11.
REQ-031 SHALL cover: queue full {00,11} with down pressed in the same cycle as step -> direction=00, queue {11,10}, no dropped.
REQ-032 SHALL cover: btn_up and btn_left rising in the same cycle with direction=01 -> up enqueued, dropped pulses once.

Source files
------------

// File: rtl/direction_ctrl.sv
// direction_ctrl: turns debounced button presses into a snake-style heading.
// Presses are edge-detected, prioritised (up > right > down > left), checked
// against the reference heading and buffered until the next game tick (step).
//
// Ports:
//   clock         in   single clock, rising edge
//   reset_n       in   synchronous active-low reset
//   btn_up/right/down/left in  debounced button levels, active-high
//   step          in   one-cycle game-tick pulse
//   direction     out  [1:0] current heading (00 up, 01 right, 10 down, 11 left)
//   turn_pending  out  high while a buffered turn exists
//   dropped       out  one-cycle pulse when a press is rejected
//
// Build option: DIRCTRL_QUEUE_EN selects a QUEUE_DEPTH-entry turn FIFO;
// without it a single last-wins pending slot is used.
module direction_ctrl #(
  parameter int unsigned QUEUE_DEPTH = 2,
  parameter logic [1:0]  INIT_DIR    = 2'b01
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       btn_up,
  input  logic       btn_right,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       step,
  output logic [1:0] direction,
  output logic       turn_pending,
  output logic       dropped
);

  // Bit index of each button equals its heading code.
  logic [3:0] btn_now;
  logic [3:0] btn_prev_q;
  logic [3:0] press;
  logic       sel_vld;
  logic [1:0] sel_dir;
  logic       multi;

  logic [1:0] dir_q, dir_d;
  logic       pend_q, pend_d;
  logic       drop_q, drop_d;

  assign btn_now = {btn_left, btn_down, btn_right, btn_up};
  assign press   = btn_now & ~btn_prev_q;

  // Pick the highest-priority press; any other simultaneous press is a drop.
  always_comb begin
    sel_vld = 1'b0;
    sel_dir = 2'b00;
    if (press[0]) begin
      sel_vld = 1'b1;
      sel_dir = 2'b00;
    end else if (press[1]) begin
      sel_vld = 1'b1;
      sel_dir = 2'b01;
    end else if (press[2]) begin
      sel_vld = 1'b1;
      sel_dir = 2'b10;
    end else if (press[3]) begin
      sel_vld = 1'b1;
      sel_dir = 2'b11;
    end
    multi = sel_vld && (press != 4'(4'b0001 << sel_dir));
  end

`ifdef DIRCTRL_QUEUE_EN
  localparam int unsigned CW = $clog2(QUEUE_DEPTH + 1);

  logic [1:0]    q_q [QUEUE_DEPTH];
  logic [1:0]    q_d [QUEUE_DEPTH];
  logic [CW-1:0] cnt_q, cnt_d, cnt_pop;
  logic [1:0]    ref_dir;
  logic          pop;

  // Pop on step, then validate the press against the pre-pop tail and push.
  always_comb begin
    q_d     = q_q;
    dir_d   = dir_q;
    drop_d  = multi;
    ref_dir = dir_q;
    for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
      if (cnt_q == CW'(i + 1)) ref_dir = q_q[i];
    end
    pop = step && (cnt_q != '0);
    if (pop) begin
      dir_d = q_q[0];
      for (int i = 0; i < int'(QUEUE_DEPTH) - 1; i++) q_d[i] = q_q[i + 1];
    end
    cnt_pop = pop ? cnt_q - CW'(1) : cnt_q;
    cnt_d   = cnt_pop;
    if (sel_vld && (sel_dir != ref_dir)) begin
      if (sel_dir == (ref_dir ^ 2'b10)) begin
        drop_d = 1'b1;
      end else if (cnt_pop == CW'(QUEUE_DEPTH)) begin
        drop_d = 1'b1;
      end else begin
        for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
          if (cnt_pop == CW'(i)) q_d[i] = sel_dir;
        end
        cnt_d = cnt_pop + CW'(1);
      end
    end
    pend_d = (cnt_d != '0);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q <= '0;
      for (int i = 0; i < int'(QUEUE_DEPTH); i++) q_q[i] <= 2'b00;
    end else begin
      cnt_q <= cnt_d;
      q_q   <= q_d;
    end
  end
`else
  localparam int unsigned QDEPTH_UNUSED = QUEUE_DEPTH;

  logic [1:0] slot_q, slot_d;
  logic       slot_vld_q, slot_vld_d;

  // Single pending slot checked against the live heading; newest valid press wins.
  always_comb begin
    dir_d      = dir_q;
    drop_d     = multi;
    slot_d     = slot_q;
    slot_vld_d = slot_vld_q;
    if (step && slot_vld_q) begin
      dir_d      = slot_q;
      slot_vld_d = 1'b0;
    end
    if (sel_vld && (sel_dir != dir_q)) begin
      if (sel_dir == (dir_q ^ 2'b10)) begin
        drop_d = 1'b1;
      end else begin
        slot_d     = sel_dir;
        slot_vld_d = 1'b1;
      end
    end
    pend_d = slot_vld_d;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      slot_q     <= 2'b00;
      slot_vld_q <= 1'b0;
    end else begin
      slot_q     <= slot_d;
      slot_vld_q <= slot_vld_d;
    end
  end
`endif

  // Previous levels reset high so a button held through reset is not a press.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      btn_prev_q <= 4'b1111;
      dir_q      <= INIT_DIR;
      pend_q     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      btn_prev_q <= btn_now;
      dir_q      <= dir_d;
      pend_q     <= pend_d;
      drop_q     <= drop_d;
    end
  end

  assign direction    = dir_q;
  assign turn_pending = pend_q;
  assign dropped      = drop_q;

endmodule

// File: tb/tb_direction_ctrl.sv
// Directed self-checking bench for direction_ctrl (QUEUE_DEPTH=2, INIT_DIR=01).
module tb_direction_ctrl;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] btn;  // {left, down, right, up}
  logic       step;
  logic [1:0] direction;
  logic       turn_pending;
  logic       dropped;

  int checks = 0;
  int errors = 0;

  localparam logic [3:0] B_UP    = 4'b0001;
  localparam logic [3:0] B_RIGHT = 4'b0010;
  localparam logic [3:0] B_DOWN  = 4'b0100;
  localparam logic [3:0] B_LEFT  = 4'b1000;

  direction_ctrl #(
    .QUEUE_DEPTH(2),
    .INIT_DIR   (2'b01)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .btn_up      (btn[0]),
    .btn_right   (btn[1]),
    .btn_down    (btn[2]),
    .btn_left    (btn[3]),
    .step        (step),
    .direction   (direction),
    .turn_pending(turn_pending),
    .dropped     (dropped)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle so registered outputs are stable.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_state(input string tag, input int d, input int p, input int r);
    check({tag, "_dir"}, int'(direction), d);
    check({tag, "_pend"}, int'(turn_pending), p);
    check({tag, "_drop"}, int'(dropped), r);
  endtask

  initial begin
    reset_n = 1'b0;
    btn     = B_UP;
    step    = 1'b0;

    // Reset with up held through and after reset.
    repeat (3) tick();
    chk_state("rst", 1, 0, 0);
    reset_n = 1'b1;
    repeat (2) tick();
    chk_state("held_up", 1, 0, 0);
    btn = 4'b0000;
    tick();

    // Press up, step two cycles later.
    btn = B_UP; tick();
    chk_state("up_press", 1, 1, 0);
    btn = 4'b0000; tick();
    check("up_wait_pend", int'(turn_pending), 1);
    step = 1'b1; tick(); step = 1'b0;
    chk_state("up_step", 0, 0, 0);

    // Back to right.
    btn = B_RIGHT; tick(); btn = 4'b0000;
    step = 1'b1; tick(); step = 1'b0;
    check("back_right_dir", int'(direction), 1);

    // Reverse press drops; same-heading press is silent.
    btn = B_LEFT; tick();
    chk_state("rev_left", 1, 0, 1);
    btn = 4'b0000; tick();
    check("rev_left_pulse_end", int'(dropped), 0);
    btn = B_RIGHT; tick();
    chk_state("same_right", 1, 0, 0);
    btn = 4'b0000; tick();

    // Up and left rise together: up wins, one drop pulse.
    btn = B_UP | B_LEFT; tick();
    chk_state("multi", 1, 1, 1);
    btn = 4'b0000; tick();
    check("multi_pulse_end", int'(dropped), 0);
    step = 1'b1; tick(); step = 1'b0;
    chk_state("multi_step", 0, 0, 0);
    btn = B_RIGHT; tick(); btn = 4'b0000;
    step = 1'b1; tick(); step = 1'b0;
    check("back_right2_dir", int'(direction), 1);

`ifdef DIRCTRL_QUEUE_EN
    // Fill queue {00,11}; third press (down) hits a full queue.
    btn = B_UP; tick();
    chk_state("q_up", 1, 1, 0);
    btn = 4'b0000; tick();
    btn = B_LEFT; tick();
    chk_state("q_left", 1, 1, 0);
    btn = 4'b0000; tick();
    btn = B_DOWN; tick();
    chk_state("q_full_down", 1, 1, 1);
    btn = 4'b0000; tick();
    check("q_full_pulse_end", int'(dropped), 0);
    step = 1'b1; tick();
    chk_state("q_pop1", 0, 1, 0);
    tick(); step = 1'b0;
    chk_state("q_pop2", 3, 0, 0);

    // Refill {00,11}, then down coincides with step.
    btn = B_UP; tick(); btn = 4'b0000; tick();
    btn = B_LEFT; tick();
    chk_state("q_refill", 3, 1, 0);
    btn = 4'b0000; tick();
    btn = B_DOWN; step = 1'b1; tick();
    chk_state("q_pushpop", 0, 1, 0);
    btn = 4'b0000; tick();
    chk_state("q_pop_11", 3, 1, 0);
    tick(); step = 1'b0;
    chk_state("q_pop_10", 2, 0, 0);
`else
    // Single slot: newer valid press overwrites older one.
    btn = B_UP; tick(); btn = 4'b0000; tick();
    btn = B_DOWN; tick();
    chk_state("s_overwrite", 1, 1, 0);
    btn = 4'b0000; tick();
    step = 1'b1; tick(); step = 1'b0;
    chk_state("s_step", 2, 0, 0);
    btn = B_UP; tick();
    chk_state("s_rev_up", 2, 0, 1);
    btn = 4'b0000; tick();
`endif

    // Mid-operation reset discards pending turn and same-cycle press/step.
    btn = B_RIGHT; tick();
    check("pre_rst_pend", int'(turn_pending), 1);
    btn = 4'b0000; tick();
    reset_n = 1'b0; btn = B_LEFT; step = 1'b1; tick();
    chk_state("mid_rst", 1, 0, 0);
    reset_n = 1'b1; btn = 4'b0000; step = 1'b0; tick();
    chk_state("post_rst", 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
